// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
// Holds the frame FSM state encoding, the default bit period and the parity mode.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } tx_state_e;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;

    localparam bit PARITY_NONE = 1'b0;
    localparam bit PARITY_EVEN = 1'b1;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts clk cycles within one serial bit and flags the last one.
// A clear restarts the period so every FSM state gets a full bit time.
module uart_baud_gen
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick
);

    localparam logic [15:0] TERMINAL = 16'(CLKS_PER_BIT - 1);

    logic [15:0] cnt_r;
    logic [15:0] cnt_next_s;
    logic        tick_r;

    // Next count: restart on clear, wrap after the terminal count.
    always_comb begin
        cnt_next_s = cnt_r;
        if (clear) begin
            cnt_next_s = 16'd0;
        end else if (cnt_r == TERMINAL) begin
            cnt_next_s = 16'd0;
        end else begin
            cnt_next_s = cnt_r + 16'd1;
        end
    end

    // Count register; the tick is registered alongside it so it mirrors cnt_r == TERMINAL.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= 16'd0;
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_next_s;
            tick_r <= (cnt_next_s == TERMINAL);
        end
    end

    assign bit_tick = tick_r;

endmodule

// File: rtl/uart_tx_drain.sv
// UART transmitter that pulls bytes from an upstream FIFO and sends 8N1 (or 8E1) frames.
// Reads honour the FIFO's write-over-read priority by retrying the fetch.
module uart_tx_drain
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter bit          PARITY_EN    = PARITY_NONE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic       fifo_empty,
    input  logic       fifo_full,
    input  logic       fifo_wr,
    input  logic [7:0] fifo_dout,
    output logic       fifo_rd,
    output logic       tx,
    output logic       busy,
    output logic       byte_done
);

    tx_state_e  state_r;
    tx_state_e  state_next_s;
    logic [7:0] shift_r;
    logic [7:0] shift_next_s;
    logic       parity_r;
    logic       parity_next_s;
    logic [2:0] bit_idx_r;
    logic [2:0] bit_idx_next_s;
    logic       tx_r;
    logic       tx_next_s;
    logic       fifo_rd_r;
    logic       busy_r;
    logic       bit_tick_s;
    logic       read_ok_s;
    logic       baud_clear_s;

    // A simultaneous non-blocked write wins inside the FIFO, so our read is dropped.
    assign read_ok_s    = fifo_rd_r && !fifo_empty && !(fifo_wr && !fifo_full);
    assign baud_clear_s = (state_next_s != state_r);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (baud_clear_s),
        .bit_tick (bit_tick_s)
    );

    // Frame sequencing and datapath next-state.
    always_comb begin
        state_next_s   = state_r;
        shift_next_s   = shift_r;
        parity_next_s  = parity_r;
        bit_idx_next_s = bit_idx_r;
        case (state_r)
            ST_IDLE: begin
                if (tx_en && !fifo_empty) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (read_ok_s) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_LOAD: begin
                shift_next_s   = fifo_dout;
                parity_next_s  = even_parity(fifo_dout);
                bit_idx_next_s = 3'd0;
                state_next_s   = ST_START;
            end
            ST_START: begin
                if (bit_tick_s) begin
                    state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_tick_s) begin
                    shift_next_s   = {1'b0, shift_r[7:1]};
                    bit_idx_next_s = bit_idx_r + 3'd1;
                    if (bit_idx_r == 3'd7) begin
                        state_next_s = PARITY_EN ? ST_PARITY : ST_STOP;
                    end else begin
                        state_next_s = ST_DATA;
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_tick_s) begin
                    state_next_s = ST_STOP;
                end else begin
                    state_next_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_tick_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Line level for the upcoming cycle, so tx can be driven straight from a flop.
    always_comb begin
        tx_next_s = 1'b1;
        case (state_next_s)
            ST_START:  tx_next_s = 1'b0;
            ST_DATA:   tx_next_s = shift_next_s[0];
            ST_PARITY: tx_next_s = parity_next_s;
            default:   tx_next_s = 1'b1;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            shift_r   <= 8'd0;
            parity_r  <= 1'b0;
            bit_idx_r <= 3'd0;
            tx_r      <= 1'b1;
            fifo_rd_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            shift_r   <= shift_next_s;
            parity_r  <= parity_next_s;
            bit_idx_r <= bit_idx_next_s;
            tx_r      <= tx_next_s;
            fifo_rd_r <= (state_next_s == ST_FETCH);
            busy_r    <= (state_next_s != ST_IDLE);
        end
    end

    assign fifo_rd   = fifo_rd_r;
    assign tx        = tx_r;
    assign busy      = busy_r;
    assign byte_done = (state_r == ST_STOP) && bit_tick_s;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Self-checking bench for uart_tx_drain: a behavioural FIFO, a frame model built from the
// byte value, table vectors, hand-timed corner cases and a randomized streaming run.
`timescale 1ns/1ps
module tb_uart_tx_drain;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance 0: no parity, fed by the FIFO model below.
    logic       tx_en0 = 1'b0;
    logic       host_wr = 1'b0;
    logic [7:0] host_wdata = 8'h00;
    logic       fifo_empty0, fifo_full0, fifo_rd0, tx0, busy0, bd0;
    logic [7:0] fifo_dout0 = 8'h00;
    logic [7:0] fmem [16];
    int         fcount = 0;
    int         rp = 0;
    int         wp = 0;

    // Instance 1: even parity, hand-driven.
    logic       tx_en1 = 1'b0;
    logic       fifo_empty1 = 1'b1;
    logic       fifo_wr1 = 1'b0;
    logic       fifo_full1 = 1'b0;
    logic [7:0] fifo_dout1 = 8'h07;
    logic       fifo_rd1, tx1, busy1, bd1;

    int n_cmp = 0;
    int n_bad = 0;
    int rd_hi0 = 0;
    int bd_cnt0 = 0;
    logic [7:0] expq[$];

    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;
    } vec_t;
    vec_t vecs[6];

    uart_tx_drain #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .tx_en(tx_en0), .fifo_empty(fifo_empty0), .fifo_full(fifo_full0),
        .fifo_wr(host_wr), .fifo_dout(fifo_dout0), .fifo_rd(fifo_rd0), .tx(tx0), .busy(busy0),
        .byte_done(bd0));

    uart_tx_drain #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .tx_en(tx_en1), .fifo_empty(fifo_empty1), .fifo_full(fifo_full1),
        .fifo_wr(fifo_wr1), .fifo_dout(fifo_dout1), .fifo_rd(fifo_rd1), .tx(tx1), .busy(busy1),
        .byte_done(bd1));

    assign fifo_empty0 = (fcount == 0);
    assign fifo_full0  = (fcount == 16);

    // 16x8 FIFO with write priority over read; data appears the cycle after a read.
    always @(posedge clk) begin
        if (host_wr && !fifo_full0) begin
            fmem[wp] <= host_wdata;
            wp       <= (wp + 1) % 16;
            fcount   <= fcount + 1;
        end else if (fifo_rd0 === 1'b1 && !fifo_empty0) begin
            fifo_dout0 <= fmem[rp];
            rp         <= (rp + 1) % 16;
            fcount     <= fcount - 1;
        end
    end

    // Activity counters for read strobes and completed frames.
    always @(posedge clk) begin
        if (fifo_rd0 === 1'b1) rd_hi0 <= rd_hi0 + 1;
        if (bd0 === 1'b1) bd_cnt0 <= bd_cnt0 + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the test sequence completed");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame as transmitted, bit 0 first: start, data LSB first, optional even parity, stop.
    function automatic logic [10:0] frame_bits(input logic [7:0] d, input bit par);
        if (par) return {1'b1, ^d, d, 1'b0};
        else     return {2'b01, d, 1'b0};
    endfunction

    task automatic wait_start(input bit sel, input int limit, input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((sel ? tx1 : tx0) !== 1'b0) && n < limit);
        n_cmp++;
        if ((sel ? tx1 : tx0) !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: got no start bit expected one within %0d cycles", name, limit);
        end
    endtask

    // Called on the first start-bit cycle; samples every cycle of the frame.
    task automatic check_frame(input bit sel, input logic [10:0] bits, input int nbits,
                               input string name);
        logic [63:0] got_tx, exp_tx, got_bd, exp_bd;
        int total;
        total  = nbits * CPB;
        got_tx = '0; exp_tx = '0; got_bd = '0; exp_bd = '0;
        for (int i = 0; i < total; i++) begin
            if (i > 0) @(negedge clk);
            got_tx[i] = sel ? tx1 : tx0;
            got_bd[i] = sel ? bd1 : bd0;
            exp_tx[i] = bits[i / CPB];
        end
        exp_bd[total-1] = 1'b1;
        check({name, "_tx"}, got_tx, exp_tx);
        check({name, "_done"}, got_bd, exp_bd);
    endtask

    task automatic push_byte(input logic [7:0] d);
        int g;
        g = 0;
        @(negedge clk);
        while (fifo_full0 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        host_wr = 1'b1;
        host_wdata = d;
        @(negedge clk);
        host_wr = 1'b0;
    endtask

    task automatic rand_pusher(input int count);
        logic [7:0] d;
        for (int k = 0; k < count; k++) begin
            d = 8'($urandom);
            repeat ($urandom_range(0, 60)) @(negedge clk);
            expq.push_back(d);
            push_byte(d);
        end
    endtask

    task automatic rand_checker(input int count);
        logic [7:0] d;
        int n;
        for (int k = 0; k < count; k++) begin
            wait_start(1'b0, 4000, "rand_start", n);
            d = (expq.size() > 0) ? expq.pop_front() : 8'h00;
            check_frame(1'b0, frame_bits(d, 1'b0), 10, "rand");
        end
    endtask

    initial begin
        logic [7:0] b1, b2;
        logic [7:0] burst[$];
        int n, r0, d0, g;
        logic seen;

        vecs[0] = '{8'hA5, 11'h34A};
        vecs[1] = '{8'h00, 11'h200};
        vecs[2] = '{8'hFF, 11'h3FE};
        vecs[3] = '{8'h01, 11'h202};
        vecs[4] = '{8'h80, 11'h300};
        vecs[5] = '{8'h5A, 11'h2B4};

        // Reset held 3 cycles with data waiting; then one 0xA5 frame.
        @(negedge clk); host_wr = 1'b1; host_wdata = 8'hA5;
        @(negedge clk); host_wr = 1'b0; tx_en0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_tx", tx0, 1'b1);
            check("rst_rd", fifo_rd0, 1'b0);
            check("rst_busy", busy0, 1'b0);
        end
        r0 = rd_hi0;
        rst = 1'b0;
        @(negedge clk);
        check("fetch_after_rst_rd", fifo_rd0, 1'b1);
        check("fetch_after_rst_busy", busy0, 1'b1);
        wait_start(1'b0, 20, "a5_start", n);
        check_frame(1'b0, frame_bits(8'hA5, 1'b0), 10, "a5");
        repeat (3) @(negedge clk);
        check("a5_idle_busy", busy0, 1'b0);
        check("a5_rd_cycles", rd_hi0 - r0, 1);

        // Table vectors with hand-computed frames.
        for (int i = 0; i < 6; i++) begin
            push_byte(vecs[i].data);
            wait_start(1'b0, 20, "vec_start", n);
            check_frame(1'b0, vecs[i].frame, 10, $sformatf("vec%0d", i));
            repeat (3) @(negedge clk);
        end

        // Write collides with the fetch: read retried, first byte sent, tx_en drops.
        b1 = 8'($urandom); b2 = 8'($urandom);
        r0 = rd_hi0;
        @(negedge clk); host_wr = 1'b1; host_wdata = b1;
        @(negedge clk); host_wr = 1'b0;
        @(negedge clk);
        check("clash_rd1", fifo_rd0, 1'b1);
        host_wr = 1'b1; host_wdata = b2; tx_en0 = 1'b0;
        @(negedge clk); host_wr = 1'b0;
        check("clash_rd2", fifo_rd0, 1'b1);
        @(negedge clk);
        check("clash_rd3", fifo_rd0, 1'b0);
        wait_start(1'b0, 20, "clash_start", n);
        check_frame(1'b0, frame_bits(b1, 1'b0), 10, "clash");
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || busy0 !== 1'b0) seen = 1'b1;
        end
        check("clash_single_frame", seen, 1'b0);
        check("clash_rd_cycles", rd_hi0 - r0, 2);

        // Burst of 15 bytes (b2 still queued plus 14 new) with 3-cycle gaps.
        burst.push_back(b2);
        for (int i = 0; i < 14; i++) begin
            burst.push_back(8'($urandom));
            push_byte(burst[i+1]);
        end
        r0 = rd_hi0; d0 = bd_cnt0;
        tx_en0 = 1'b1;
        for (int k = 0; k < 15; k++) begin
            wait_start(1'b0, 20, "burst_start", n);
            if (k > 0) check("burst_gap", n, 4);
            check_frame(1'b0, frame_bits(burst[k], 1'b0), 10, "burst");
        end
        repeat (5) @(negedge clk);
        check("burst_idle_busy", busy0, 1'b0);
        check("burst_rd_pulses", rd_hi0 - r0, 15);
        check("burst_done_pulses", bd_cnt0 - d0, 15);

        // Reset during data bit 2 of 0x3C; FIFO empty afterwards.
        push_byte(8'h3C);
        wait_start(1'b0, 20, "abort_start", n);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        d0 = bd_cnt0;
        @(negedge clk);
        rst = 1'b0;
        check("abort_tx", tx0, 1'b1);
        check("abort_busy", busy0, 1'b0);
        check("abort_rd", fifo_rd0, 1'b0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || busy0 !== 1'b0) seen = 1'b1;
        end
        check("abort_stays_idle", seen, 1'b0);
        check("abort_no_done", bd_cnt0 - d0, 0);

        // Even-parity instance sends 0x07.
        @(negedge clk); fifo_empty1 = 1'b0; tx_en1 = 1'b1;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (fifo_rd1 !== 1'b1 && g < 20);
        check("par_rd", fifo_rd1, 1'b1);
        @(negedge clk); fifo_empty1 = 1'b1; tx_en1 = 1'b0;
        wait_start(1'b1, 20, "par_start", n);
        check_frame(1'b1, frame_bits(8'h07, 1'b1), 11, "par07");
        repeat (3) @(negedge clk);
        check("par_idle_busy", busy1, 1'b0);

        // Randomized streaming with writes at arbitrary times, including during fetches.
        fork
            rand_pusher(20);
            rand_checker(20);
        join
        repeat (10) @(negedge clk);
        check("rand_idle_busy", busy0, 1'b0);
        check("rand_drained", fcount, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_drain.md
UART_TX_DRAIN -- requirements
Module: uart_tx_drain

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal range 2..65535.
REQ-002 Parameter PARITY_EN, default 0: 1 inserts an even-parity bit between the data bits and the stop bit.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 tx_en  input  1  level enable; low = no new frame started.
REQ-006 fifo_empty  input  1  upstream 16x8 FIFO empty flag.
REQ-007 fifo_full  input  1  upstream FIFO full flag.
REQ-008 fifo_wr  input  1  tap of the upstream write strobe into the same FIFO.
REQ-009 fifo_dout  input  8  FIFO read data; valid the cycle after a read is accepted.
REQ-010 fifo_rd  output  1  read strobe to the FIFO.
REQ-011 tx  output  1  serial line; idle high.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 byte_done  output  1  one-cycle pulse when a stop bit completes.

Function
REQ-014 FSM states: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
REQ-015 IDLE -> FETCH when tx_en=1 and fifo_empty=0; otherwise stay in IDLE.
REQ-016 fifo_rd = 1 exactly while in FETCH (Moore output).
REQ-017 Read accepted = fifo_rd && !fifo_empty && !(fifo_wr && !fifo_full); the FIFO gives write priority over read.
REQ-018 FETCH -> LOAD if the read is accepted; otherwise stay in FETCH and re-assert fifo_rd on the next cycle.
REQ-019 LOAD: capture fifo_dout into an 8-bit shift register, compute the parity bit (XOR of the 8 bits), go to START; 1 cycle.
REQ-020 START: tx=0 for CLKS_PER_BIT cycles.
REQ-021 DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each; a 3-bit index wraps 7->0 on exit.
REQ-022 PARITY, entered only if PARITY_EN=1: tx=parity bit for CLKS_PER_BIT cycles.
REQ-023 STOP: tx=1 for CLKS_PER_BIT cycles; on the last cycle, assert byte_done and go to IDLE.
REQ-024 The gap between back-to-back frames is exactly 3 cycles of tx=1 (IDLE, FETCH, LOAD) beyond the stop bit when no FETCH retry occurs.
REQ-025 The baud counter is 16 bits wide, reloads to 0 on every state entry, and terminal count is CLKS_PER_BIT-1.
REQ-026 tx_en deassert mid-frame: the current frame completes; the FSM then holds in IDLE.
REQ-027 fifo_empty rising during a frame has no effect on that frame.
REQ-028 tx is registered, so it has no combinational path from inputs.

Reset
REQ-029 When rst=1 at a clock edge: state=IDLE, tx=1, fifo_rd=0, busy=0, byte_done=0, counters=0, shift register=0.
REQ-030 Reset mid-frame aborts the frame: tx=1 from the next cycle, no byte_done, and the byte is lost.
REQ-031 rst has priority over every other input.

Structure
REQ-032 Package uart_tx_pkg holds the state enum, the default CLKS_PER_BIT, and the parity-mode constant.
REQ-033 One sub-module, uart_baud_gen: a counter with clear input and bit_tick output, instantiated once.

Verification (CLKS_PER_BIT=4 unless noted)
REQ-034 rst=1 for 3 cycles with fifo_empty=0 -> tx=1, fifo_rd=0, busy=0 throughout; FETCH is entered 1 cycle after release.
REQ-035 One byte 0xA5, PARITY_EN=0 -> one 1-cycle fifo_rd; tx = 0,1,0,1,0,0,1,0,1,1 at 4 cycles each; byte_done on the 40th cycle after LOAD.
REQ-036 fifo_wr=1, fifo_full=0 during the FETCH cycle -> fifo_rd high 2 consecutive cycles; exactly one frame sent, carrying the intended byte.
REQ-037 FIFO preloaded with 15 bytes, tx_en=1 -> 15 fifo_rd pulses, 15 byte_done pulses, 3-cycle inter-frame gaps, then IDLE with busy=0.
REQ-038 rst at the 3rd data bit of 0x3C, with fifo_empty=1 after release -> tx=1 next cycle, no byte_done, busy=0, FSM stays IDLE.
REQ-039 PARITY_EN=1, byte 0x07 -> parity bit 1 sent for 4 cycles before the stop bit; frame length 44 cycles from START.
